// File: rtl/cond_branch_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : cond_branch_tracker_if
//  Description : Token-in / result-out bundle for cond_branch_tracker.
//                The tracker sits on the slave modport. The tokenizer and
//                line-emitter side sits on the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cond_branch_tracker_if #(
    parameter int DEPTH_W = 4,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_kind;
    logic               in_defined;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_kind;
    logic [DEPTH_W-1:0] out_depth;
    logic               out_active;
    logic [2:0]         out_err;
    logic               err_sticky;
    logic [CNT_W-1:0]   kept_cnt;
    logic [CNT_W-1:0]   drop_cnt;

    modport slave (
        input  in_valid, in_kind, in_defined, out_ready,
        output in_ready, out_valid, out_kind, out_depth, out_active,
               out_err, err_sticky, kept_cnt, drop_cnt
    );

    modport master (
        output in_valid, in_kind, in_defined, out_ready,
        input  in_ready, out_valid, out_kind, out_depth, out_active,
               out_err, err_sticky, kept_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cond_branch_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : cond_branch_tracker
//  Description : Streaming evaluator for `ifdef/`ifndef/`elsif/`else/`endif
//                tokens. Keeps a nesting stack of {parent_active, taken,
//                seen_else}. Marks every token kept or dropped, tags it with
//                its indent depth and reports structural errors.
//                The result is held in a single registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_branch_tracker #(
    parameter int MAX_DEPTH = 8,   // nesting levels held on the stack (>=1)
    parameter int DEPTH_W   = 4,   // 2**DEPTH_W > MAX_DEPTH; must match bus
    parameter int CNT_W     = 16   // statistics counter width; must match bus
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cond_branch_tracker_if.slave bus
);
    // Token kinds
    localparam logic [2:0] c_kind_line   = 3'd0;
    localparam logic [2:0] c_kind_ifdef  = 3'd1;
    localparam logic [2:0] c_kind_ifndef = 3'd2;
    localparam logic [2:0] c_kind_elsif  = 3'd3;
    localparam logic [2:0] c_kind_else   = 3'd4;
    localparam logic [2:0] c_kind_endif  = 3'd5;
    localparam logic [2:0] c_kind_eof    = 3'd6;

    // Error codes
    localparam logic [2:0] c_err_none       = 3'd0;
    localparam logic [2:0] c_err_overflow   = 3'd1;
    localparam logic [2:0] c_err_underflow  = 3'd2;
    localparam logic [2:0] c_err_elsif_else = 3'd3;
    localparam logic [2:0] c_err_dbl_else   = 3'd4;
    localparam logic [2:0] c_err_unterm     = 3'd5;

    // Stack storage is sized to the full index range so a DEPTH_W-bit
    // pointer always addresses a real bit; only [MAX_DEPTH-1:0] is used.
    localparam int                 c_stk_n     = 1 << DEPTH_W;
    localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(MAX_DEPTH);

    // Nesting state
    logic [DEPTH_W-1:0] depth_q,      depth_d;
    logic               cur_active_q, cur_active_d;
    logic [c_stk_n-1:0] parent_q,     parent_d;
    logic [c_stk_n-1:0] taken_q,      taken_d;
    logic [c_stk_n-1:0] seen_else_q,  seen_else_d;

    // Status / statistics
    logic               err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]   kept_q,       kept_d;
    logic [CNT_W-1:0]   drop_q,       drop_d;

    // Output stage
    logic               out_valid_q;
    logic [2:0]         out_kind_q;
    logic [DEPTH_W-1:0] out_depth_q,  out_depth_d;
    logic               out_active_q, out_active_d;
    logic [2:0]         out_err_q,    out_err_d;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_empty;
    logic [DEPTH_W-1:0] w_top;
    logic               w_top_parent;
    logic               w_top_taken;
    logic               w_top_seen_else;
    logic               w_cond;

    assign w_in_ready      = !out_valid_q || bus.out_ready;
    assign w_accept        = bus.in_valid && w_in_ready;
    assign w_empty         = (depth_q == '0);
    assign w_top           = depth_q - 1'b1;
    assign w_top_parent    = parent_q[w_top];
    assign w_top_taken     = taken_q[w_top];
    assign w_top_seen_else = seen_else_q[w_top];
    assign w_cond          = (bus.in_kind == c_kind_ifndef) ? !bus.in_defined
                                                            :  bus.in_defined;

    // Evaluate the accepted token: result fields and next nesting state.
    // An erroring token reports the current depth/liveness and leaves the
    // stack untouched; EOF always clears the stack regardless.
    always_comb begin
        depth_d      = depth_q;
        cur_active_d = cur_active_q;
        parent_d     = parent_q;
        taken_d      = taken_q;
        seen_else_d  = seen_else_q;
        err_sticky_d = err_sticky_q;
        kept_d       = kept_q;
        drop_d       = drop_q;
        out_depth_d  = depth_q;
        out_active_d = cur_active_q;
        out_err_d    = c_err_none;

        if (w_accept) begin
            case (bus.in_kind)
                c_kind_line: begin
                    if (cur_active_q) begin
                        if (kept_q != '1) kept_d = kept_q + 1'b1;
                    end else begin
                        if (drop_q != '1) drop_d = drop_q + 1'b1;
                    end
                end
                c_kind_ifdef, c_kind_ifndef: begin
                    if (depth_q == c_max_depth) begin
                        out_err_d = c_err_overflow;
                    end else begin
                        parent_d[depth_q]    = cur_active_q;
                        taken_d[depth_q]     = w_cond;
                        seen_else_d[depth_q] = 1'b0;
                        cur_active_d         = cur_active_q && w_cond;
                        depth_d              = depth_q + 1'b1;
                    end
                end
                c_kind_elsif: begin
                    if (w_empty) begin
                        out_err_d = c_err_underflow;
                    end else if (w_top_seen_else) begin
                        out_err_d = c_err_elsif_else;
                    end else begin
                        out_depth_d    = w_top;
                        out_active_d   = w_top_parent;
                        cur_active_d   = w_top_parent && !w_top_taken && bus.in_defined;
                        taken_d[w_top] = w_top_taken || bus.in_defined;
                    end
                end
                c_kind_else: begin
                    if (w_empty) begin
                        out_err_d = c_err_underflow;
                    end else if (w_top_seen_else) begin
                        out_err_d = c_err_dbl_else;
                    end else begin
                        out_depth_d        = w_top;
                        out_active_d       = w_top_parent;
                        cur_active_d       = w_top_parent && !w_top_taken;
                        taken_d[w_top]     = 1'b1;
                        seen_else_d[w_top] = 1'b1;
                    end
                end
                c_kind_endif: begin
                    if (w_empty) begin
                        out_err_d = c_err_underflow;
                    end else begin
                        out_depth_d  = w_top;
                        out_active_d = w_top_parent;
                        cur_active_d = w_top_parent;
                        depth_d      = w_top;
                    end
                end
                c_kind_eof: begin
                    // Unterminated blocks report like any other error
                    // (current depth and liveness); a clean EOF is depth 0.
                    if (!w_empty) begin
                        out_err_d = c_err_unterm;
                    end else begin
                        out_depth_d  = '0;
                        out_active_d = 1'b1;
                    end
                    depth_d      = '0;
                    cur_active_d = 1'b1;
                end
                default: begin
                    // Undefined kind: echoed as a passive token, no state change.
                end
            endcase

            if (bus.in_kind == c_kind_eof) begin
                err_sticky_d = 1'b0;
            end else if (out_err_d != c_err_none) begin
                err_sticky_d = 1'b1;
            end
        end
    end

    // State and output registers. Reset drops any pending result and
    // empties the stack in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q      <= '0;
            cur_active_q <= 1'b1;
            parent_q     <= '0;
            taken_q      <= '0;
            seen_else_q  <= '0;
            err_sticky_q <= 1'b0;
            kept_q       <= '0;
            drop_q       <= '0;
            out_valid_q  <= 1'b0;
            out_kind_q   <= '0;
            out_depth_q  <= '0;
            out_active_q <= 1'b0;
            out_err_q    <= '0;
        end else begin
            depth_q      <= depth_d;
            cur_active_q <= cur_active_d;
            parent_q     <= parent_d;
            taken_q      <= taken_d;
            seen_else_q  <= seen_else_d;
            err_sticky_q <= err_sticky_d;
            kept_q       <= kept_d;
            drop_q       <= drop_d;
            if (w_accept) begin
                out_valid_q  <= 1'b1;
                out_kind_q   <= bus.in_kind;
                out_depth_q  <= out_depth_d;
                out_active_q <= out_active_d;
                out_err_q    <= out_err_d;
            end else if (bus.out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_kind   = out_kind_q;
    assign bus.out_depth  = out_depth_q;
    assign bus.out_active = out_active_q;
    assign bus.out_err    = out_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.kept_cnt   = kept_q;
    assign bus.drop_cnt   = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_cond_branch_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cond_branch_tracker
//  Description : Directed, table-driven bench for cond_branch_tracker plus
//                hand sequences for overflow, back-pressure and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_branch_tracker;
    localparam logic [2:0] LN = 3'd0, IFD = 3'd1, IFN = 3'd2, ELF = 3'd3,
                           ELS = 3'd4, END = 3'd5, EOF = 3'd6;

    typedef struct {
        logic [2:0] kind;
        logic       def;
        logic [3:0] depth;
        logic       active;
        logic [2:0] err;
        logic       sticky;
        logic       skip_da;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_kept = 0;
    int   exp_drop = 0;
    vec_t vecs[$];

    cond_branch_tracker_if #(.DEPTH_W(4), .CNT_W(16)) bus ();

    cond_branch_tracker #(.MAX_DEPTH(8), .DEPTH_W(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic [2:0] k, input logic d, input logic [3:0] dep,
                               input logic a, input logic [2:0] e, input logic s,
                               input logic skip);
        vec_t r;
        r.kind = k; r.def = d; r.depth = dep; r.active = a;
        r.err = e; r.sticky = s; r.skip_da = skip;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    endtask

    // Drive one token starting at a negedge; returns at the next negedge.
    task automatic apply(input logic [2:0] k, input logic d);
        bus.in_valid = 1'b1; bus.in_kind = k; bus.in_defined = d;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0; bus.in_kind = 3'd0; bus.in_defined = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int idx, input logic [2:0] k,
                           input logic [3:0] dep, input logic a, input logic [2:0] e,
                           input logic s, input logic skip);
        chk({nm, ".valid"}, idx, int'(bus.out_valid), 1);
        chk({nm, ".kind"},  idx, int'(bus.out_kind), int'(k));
        if (!skip) begin
            chk({nm, ".depth"},  idx, int'(bus.out_depth), int'(dep));
            chk({nm, ".active"}, idx, int'(bus.out_active), int'(a));
        end
        chk({nm, ".err"},    idx, int'(bus.out_err), int'(e));
        chk({nm, ".sticky"}, idx, int'(bus.err_sticky), int'(s));
        if (k == LN) begin
            if (a) exp_kept++;
            else   exp_drop++;
        end
        chk({nm, ".kept"}, idx, int'(bus.kept_cnt), exp_kept);
        chk({nm, ".drop"}, idx, int'(bus.drop_cnt), exp_drop);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_kind = 3'd0; bus.in_defined = 1'b0;
        bus.out_ready = 1'b1;

        // kind, def, depth, active, err, sticky, skip depth/active
        vecs.push_back(v(IFD,1,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,1,0,0,0));
        vecs.push_back(v(ELF,1,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,0,0,0,0));
        vecs.push_back(v(ELS,0,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,0,0,0,0));
        vecs.push_back(v(END,0,0,1,0,0,0));
        vecs.push_back(v(IFD,0,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,0,0,0,0));
        vecs.push_back(v(ELF,1,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,1,0,0,0));
        vecs.push_back(v(ELS,0,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,0,0,0,0));
        vecs.push_back(v(END,0,0,1,0,0,0));
        vecs.push_back(v(IFD,0,0,1,0,0,0)); vecs.push_back(v(IFD,1,1,0,0,0,0));
        vecs.push_back(v(LN ,0,2,0,0,0,0)); vecs.push_back(v(END,0,1,0,0,0,0));
        vecs.push_back(v(END,0,0,1,0,0,0));
        vecs.push_back(v(IFN,0,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,1,0,0,0));
        vecs.push_back(v(END,0,0,1,0,0,0));
        vecs.push_back(v(END,0,0,1,2,1,0)); vecs.push_back(v(LN ,0,0,1,0,1,0));
        vecs.push_back(v(EOF,0,0,1,0,0,0));
        vecs.push_back(v(IFD,1,0,1,0,0,0)); vecs.push_back(v(ELS,0,0,1,0,0,0));
        vecs.push_back(v(ELS,0,1,0,4,1,0)); vecs.push_back(v(ELF,1,1,0,3,1,0));
        vecs.push_back(v(END,0,0,1,0,1,0)); vecs.push_back(v(EOF,0,0,1,0,0,0));
        vecs.push_back(v(IFD,1,0,1,0,0,0)); vecs.push_back(v(EOF,0,0,1,5,0,1));
        vecs.push_back(v(LN ,0,0,1,0,0,0));
        vecs.push_back(v(ELF,1,0,1,2,1,0)); vecs.push_back(v(ELS,0,0,1,2,1,0));
        vecs.push_back(v(EOF,0,0,1,0,0,0));
        vecs.push_back(v(IFN,1,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,0,0,0,0));
        vecs.push_back(v(ELF,0,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,0,0,0,0));
        vecs.push_back(v(ELS,0,0,1,0,0,0)); vecs.push_back(v(LN ,0,1,1,0,0,0));
        vecs.push_back(v(END,0,0,1,0,0,0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.out_valid",  0, int'(bus.out_valid), 0);
        chk("rst.in_ready",   0, int'(bus.in_ready), 1);
        chk("rst.out_kind",   0, int'(bus.out_kind), 0);
        chk("rst.out_depth",  0, int'(bus.out_depth), 0);
        chk("rst.out_active", 0, int'(bus.out_active), 0);
        chk("rst.out_err",    0, int'(bus.out_err), 0);
        chk("rst.sticky",     0, int'(bus.err_sticky), 0);
        chk("rst.kept",       0, int'(bus.kept_cnt), 0);
        chk("rst.drop",       0, int'(bus.drop_cnt), 0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].kind, vecs[i].def);
            chk_out("vec", i, vecs[i].kind, vecs[i].depth, vecs[i].active,
                    vecs[i].err, vecs[i].sticky, vecs[i].skip_da);
        end

        // Overflow at MAX_DEPTH=8, then unwind and underflow
        for (int i = 0; i < 8; i++) begin
            apply(IFD, 1'b1);
            chk_out("ovf.push", i, IFD, 4'(i), 1'b1, 3'd0, 1'b0, 1'b0);
        end
        apply(IFD, 1'b1);
        chk_out("ovf.ninth", 8, IFD, 4'd8, 1'b1, 3'd1, 1'b1, 1'b0);
        apply(LN, 1'b0);
        chk_out("ovf.line", 8, LN, 4'd8, 1'b1, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply(END, 1'b0);
            chk_out("ovf.pop", i, END, 4'(7 - i), 1'b1, 3'd0, 1'b1, 1'b0);
        end
        apply(END, 1'b0);
        chk_out("ovf.under", 0, END, 4'd0, 1'b1, 3'd2, 1'b1, 1'b0);
        apply(EOF, 1'b0);
        chk_out("ovf.eof", 0, EOF, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0);

        // Back-pressure: out_ready low for 5 cycles with tokens offered
        @(posedge clk); @(negedge clk);
        chk("bp.drained", 0, int'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_kind = IFD; bus.in_defined = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_kind = LN; bus.in_defined = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp.in_ready",  c, int'(bus.in_ready), 0);
            chk("bp.out_valid", c, int'(bus.out_valid), 1);
            chk("bp.hold_kind", c, int'(bus.out_kind), int'(IFD));
            chk("bp.hold_dep",  c, int'(bus.out_depth), 0);
            chk("bp.hold_act",  c, int'(bus.out_active), 1);
            if (c < 4) begin
                @(posedge clk); @(negedge clk);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_out("bp.tokB", 0, LN, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0);
        bus.in_kind = END;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0; bus.in_kind = 3'd0;
        chk_out("bp.tokC", 0, END, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("bp.idle", 0, int'(bus.out_valid), 0);

        // Reset in the middle of an open block with a stalled result
        apply(IFD, 1'b1);
        apply(IFD, 1'b1);
        chk_out("mrst.pre", 0, IFD, 4'd1, 1'b1, 3'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("mrst.out_valid", 0, int'(bus.out_valid), 0);
        chk("mrst.in_ready",  0, int'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        exp_kept = 0; exp_drop = 0;
        apply(LN, 1'b0);
        chk_out("mrst.line", 0, LN, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
